// File: rtl/ps2_mouse_tracker_if.sv
// Byte stream from the PS/2 receiver into the mouse tracker.
// The receiver drives a byte and a one-cycle strobe; there is no backpressure.
interface ps2_mouse_tracker_if;
    logic [7:0] iData;
    logic       iDataEn;

    modport master (output iData, output iDataEn);
    modport slave  (input  iData, input  iDataEn);
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets into a screen-clamped cursor and button levels.
// Optional `define MOUSE_ACCEL_EN doubles any delta of magnitude 8 or more.
//
// state | meaning
// B0    | await header byte (sync bit [3] must be set)
// B1    | await X delta byte
// B2    | await Y delta byte
// UPD   | apply packet to position/buttons; a strobe here is taken as a header
module ps2_mouse_tracker #(
    parameter int X_MAX          = 319,
    parameter int Y_MAX          = 239,
    parameter int X_INIT         = 160,
    parameter int Y_INIT         = 120,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 iResetn,
    ps2_mouse_tracker_if.slave   bus,
    output logic [8:0]           oMouseX,
    output logic [7:0]           oMouseY,
    output logic                 oLeftBtn,
    output logic                 oRightBtn,
    output logic                 oPacketValid,
    output logic                 oSyncErr
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]     TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    typedef enum logic [1:0] {B0, B1, B2, UPD} state_t;

    state_t        state, stateNext;
    logic [5:0]    hdr, hdrNext;       // {ovfY, ovfX, signY, signX, right, left}
    logic [7:0]    dxByte, dxByteNext;
    logic [7:0]    dyByte, dyByteNext;
    logic [CW-1:0] toCnt, toCntNext;
    logic          syncErrNext;
    logic          timeout;

    logic signed [10:0] dxRaw, dyRaw, dxEff, dyEff, sumX, sumY;
    logic [8:0]         clampX;
    logic [7:0]         clampY;

    assign timeout = (toCnt == TO_LAST);

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state    <= B0;
            hdr      <= '0;
            dxByte   <= '0;
            dyByte   <= '0;
            toCnt    <= '0;
            oSyncErr <= 1'b0;
        end else begin
            state    <= stateNext;
            hdr      <= hdrNext;
            dxByte   <= dxByteNext;
            dyByte   <= dyByteNext;
            toCnt    <= toCntNext;
            oSyncErr <= syncErrNext;
        end
    end

    always_comb begin
        stateNext   = state;
        hdrNext     = hdr;
        dxByteNext  = dxByte;
        dyByteNext  = dyByte;
        toCntNext   = '0;
        syncErrNext = 1'b0;
        case (state)
            B0, UPD: begin
                stateNext = B0;
                if (bus.iDataEn) begin
                    if (bus.iData[3]) begin
                        hdrNext   = {bus.iData[7:4], bus.iData[1:0]};
                        stateNext = B1;
                    end else begin
                        syncErrNext = 1'b1;
                    end
                end
            end
            B1: begin
                if (bus.iDataEn) begin
                    dxByteNext = bus.iData;
                    stateNext  = B2;
                end else if (timeout) begin
                    syncErrNext = 1'b1;
                    stateNext   = B0;
                end else begin
                    toCntNext = toCnt + CW'(1);
                end
            end
            B2: begin
                if (bus.iDataEn) begin
                    dyByteNext = bus.iData;
                    stateNext  = UPD;
                end else if (timeout) begin
                    syncErrNext = 1'b1;
                    stateNext   = B0;
                end else begin
                    toCntNext = toCnt + CW'(1);
                end
            end
            default: stateNext = B0;
        endcase
    end

    // An overflowed axis contributes nothing for this packet.
    assign dxRaw = hdr[4] ? 11'sd0 : $signed({{2{hdr[2]}}, hdr[2], dxByte});
    assign dyRaw = hdr[5] ? 11'sd0 : $signed({{2{hdr[3]}}, hdr[3], dyByte});

`ifdef MOUSE_ACCEL_EN
    assign dxEff = ((dxRaw >= 11'sd8) || (dxRaw <= -11'sd8)) ? (dxRaw <<< 1) : dxRaw;
    assign dyEff = ((dyRaw >= 11'sd8) || (dyRaw <= -11'sd8)) ? (dyRaw <<< 1) : dyRaw;
`else
    assign dxEff = dxRaw;
    assign dyEff = dyRaw;
`endif

    // PS/2 Y is up-positive while screen Y grows downward.
    assign sumX = $signed({2'b00, oMouseX}) + dxEff;
    assign sumY = $signed({3'b000, oMouseY}) - dyEff;

    assign clampX = (sumX < 11'sd0)   ? 9'd0 :
                    (sumX > X_MAX_S)  ? 9'(X_MAX) : sumX[8:0];
    assign clampY = (sumY < 11'sd0)   ? 8'd0 :
                    (sumY > Y_MAX_S)  ? 8'(Y_MAX) : sumY[7:0];

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            oMouseX      <= 9'(X_INIT);
            oMouseY      <= 8'(Y_INIT);
            oLeftBtn     <= 1'b0;
            oRightBtn    <= 1'b0;
            oPacketValid <= 1'b0;
        end else begin
            oPacketValid <= (state == UPD);
            if (state == UPD) begin
                oMouseX   <= clampX;
                oMouseY   <= clampY;
                oLeftBtn  <= hdr[0];
                oRightBtn <= hdr[1];
            end
        end
    end

endmodule
